mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 13 +
 rtl/mem_port_arbiter_rr_pick.sv | 30 +++
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared defaults and FSM encoding for the memory-port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_ADDR_W  = 32;
  localparam int unsigned DEF_DATA_W  = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Rotate-priority encoder: first requesting index at or above ptr, wrapping modulo N.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  win_oh_o,
  output logic [IW-1:0] win_idx_o,
  output logic          win_vld_o
);

  logic [IW-1:0] idx;

  always_comb begin
    win_oh_o  = '0;
    win_idx_o = '0;
    win_vld_o = 1'b0;
    idx       = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = IW'((32'(ptr_i) + i) % N);
      if (!win_vld_o && req_i[idx]) begin
        win_vld_o     = 1'b1;
        win_oh_o[idx] = 1'b1;
        win_idx_o     = idx;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin memory-port arbiter with lockable ownership and a fixed-latency read return path.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         memory_controller_address,
  output logic                      memory_controller_write_enable,
  output logic [DATA_W-1:0]         memory_controller_in,
  input  logic [DATA_W-1:0]         memory_controller_out
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  arb_state_e          state_q, state_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [IW-1:0]       ptr_q, ptr_d;

  logic [NUM_REQ-1:0]  pick_oh;
  logic [IW-1:0]       pick_idx;
  logic                pick_vld;

  logic                hold_c;
  logic                accept;
  logic [IW-1:0]       win_idx;

  logic                s1_vld_q, s2_vld_q;
  logic [IW-1:0]       s1_idx_q, s2_idx_q;
  logic [NUM_REQ-1:0]  rvalid_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [ADDR_W-1:0]   mc_addr_q;
  logic                mc_we_q;
  logic [DATA_W-1:0]   mc_wdata_q;

  logic [ADDR_W-1:0]   addr_a  [NUM_REQ];
  logic [DATA_W-1:0]   wdata_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a[g]  = addr[g*ADDR_W +: ADDR_W];
    assign wdata_a[g] = wdata[g*DATA_W +: DATA_W];
  end

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .win_oh_o  (pick_oh),
    .win_idx_o (pick_idx),
    .win_vld_o (pick_vld)
  );

  // Grant selection and next-state: an owner keeps the port only while it holds both req and lock.
  always_comb begin
    hold_c  = (state_q == OWNED) && req[owner_q] && lock[owner_q];
    gnt     = '0;
    accept  = 1'b0;
    win_idx = pick_idx;
    state_d = IDLE;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    if (!reset) begin
      if (hold_c) begin
        gnt[owner_q] = 1'b1;
        win_idx      = owner_q;
        accept       = 1'b1;
      end else if (pick_vld) begin
        gnt    = pick_oh;
        accept = 1'b1;
      end
    end
    if (accept) begin
      ptr_d   = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);
      owner_d = win_idx;
      if (lock[win_idx]) state_d = OWNED;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      ptr_q      <= '0;
      s1_vld_q   <= 1'b0;
      s1_idx_q   <= '0;
      s2_vld_q   <= 1'b0;
      s2_idx_q   <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      mc_addr_q  <= '0;
      mc_we_q    <= 1'b0;
      mc_wdata_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      mc_we_q  <= 1'b0;
      if (accept) begin
        mc_addr_q  <= addr_a[win_idx];
        mc_we_q    <= we[win_idx];
        mc_wdata_q <= wdata_a[win_idx];
      end
      // Read return: memory data arrives one cycle after the address, captured one stage later.
      s1_vld_q <= accept && !we[win_idx];
      s1_idx_q <= win_idx;
      s2_vld_q <= s1_vld_q;
      s2_idx_q <= s1_idx_q;
      rvalid_q <= '0;
      if (s2_vld_q) begin
        rvalid_q[s2_idx_q] <= 1'b1;
        rdata_q            <= memory_controller_out;
      end
    end
  end

  assign rvalid                         = rvalid_q;
  assign rdata                          = rdata_q;
  assign memory_controller_address      = mc_addr_q;
  assign memory_controller_write_enable = mc_we_q;
  assign memory_controller_in           = mc_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a one-cycle-latency memory model.
module tb_mem_port_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req, lock, we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt, rvalid;
  logic [DW-1:0]   rdata;
  logic [AW-1:0]   mc_addr;
  logic            mc_we;
  logic [DW-1:0]   mc_in;
  logic [DW-1:0]   mc_out;

  int checks;
  int errors;

  mem_port_arbiter #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .DATA_W  (DW)
  ) dut (
    .clk                            (clk),
    .reset                          (reset),
    .req                            (req),
    .lock                           (lock),
    .we                             (we),
    .addr                           (addr),
    .wdata                          (wdata),
    .gnt                            (gnt),
    .rvalid                         (rvalid),
    .rdata                          (rdata),
    .memory_controller_address      (mc_addr),
    .memory_controller_write_enable (mc_we),
    .memory_controller_in           (mc_in),
    .memory_controller_out          (mc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory returns data for the address presented in the previous cycle.
  always @(posedge clk) mc_out <= mem_val(mc_addr);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
    we[i]             = w;
    addr[i*AW +: AW]  = a;
    wdata[i*DW +: DW] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [3:0] e;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    req    = '0;
    lock   = '0;
    we     = '0;
    addr   = '0;
    wdata  = '0;
    for (int i = 0; i < 4; i++) set_port(i, 1'b0, 32'h100 + 32'(4 * i), 32'h0);

    // Reset: no grants while reset is high, registered outputs cleared.
    req = 4'hF;
    #1;
    check("gnt_in_reset", gnt, 0);
    cyc();
    cyc();
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_mc_addr", mc_addr, 0);
    check("rst_mc_we", mc_we, 0);
    check("rst_mc_in", mc_in, 0);
    reset = 1'b0;

    // Round-robin with all requesters reading.
    for (int k = 0; k < 8; k++) begin
      req = (k < 5) ? 4'hF : 4'h0;
      #1;
      e = (k < 5) ? (4'b0001 << (k % 4)) : 4'b0000;
      check("rr_gnt", gnt, e);
      if (k >= 1 && k <= 5) check("rr_addr", mc_addr, 32'h100 + 32'(4 * ((k - 1) % 4)));
      if (k >= 3) begin
        e = 4'b0001 << ((k - 3) % 4);
        check("rr_rvalid", rvalid, e);
        check("rr_rdata", rdata, mem_val(32'h100 + 32'(4 * ((k - 3) % 4))));
      end
      cyc();
    end
    check("rr_idle_rvalid", rvalid, 0);

    // Single read by requester 2 (ptr = 1).
    set_port(2, 1'b0, 32'h10, 32'h0);
    req = 4'b0100;
    #1;
    check("rd_gnt", gnt, 4'b0100);
    cyc();
    req = 4'b0000;
    #1;
    check("rd_addr", mc_addr, 32'h10);
    check("rd_we", mc_we, 0);
    check("rd_rvalid_c1", rvalid, 0);
    cyc();
    check("rd_rvalid_c2", rvalid, 0);
    cyc();
    check("rd_rvalid", rvalid, 4'b0100);
    check("rd_rdata", rdata, 32'hDEADBEEF);
    cyc();
    check("rd_rvalid_off", rvalid, 0);

    // Write by requester 0 (ptr = 3, wraps to 0).
    set_port(0, 1'b1, 32'h8, 32'h55);
    req = 4'b0001;
    #1;
    check("wr_gnt", gnt, 4'b0001);
    cyc();
    req = 4'b0000;
    #1;
    check("wr_addr", mc_addr, 32'h8);
    check("wr_we", mc_we, 1);
    check("wr_in", mc_in, 32'h55);
    check("wr_rvalid_c1", rvalid, 0);
    cyc();
    check("wr_we_off", mc_we, 0);
    check("wr_addr_hold", mc_addr, 32'h8);
    check("wr_rvalid_c2", rvalid, 0);
    cyc();
    check("wr_rvalid_c3", rvalid, 0);
    set_port(0, 1'b0, 32'h40, 32'h0);

    // Requester 1 locks for three accesses while 0 and 3 wait (ptr = 1).
    set_port(1, 1'b0, 32'h20, 32'h0);
    set_port(3, 1'b0, 32'h30, 32'h0);
    req  = 4'b1011;
    lock = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("lock_gnt", gnt, 4'b0010);
      cyc();
    end
    req = 4'b1001;
    #1;
    check("lock_rel_gnt3", gnt, 4'b1000);
    cyc();
    lock = 4'b0000;
    #1;
    check("lock_rel_gnt0", gnt, 4'b0001);
    cyc();
    req = 4'b0000;
    for (int c = 0; c < 4; c++) cyc();

    // Back-to-back reads by 3, 0, 1 return in order (ptr = 1).
    set_port(3, 1'b0, 32'h30, 32'h0);
    set_port(0, 1'b0, 32'h40, 32'h0);
    set_port(1, 1'b0, 32'h50, 32'h0);
    req = 4'b1000;
    #1;
    check("b2b_gnt3", gnt, 4'b1000);
    cyc();
    req = 4'b0001;
    #1;
    check("b2b_gnt0", gnt, 4'b0001);
    cyc();
    req = 4'b0010;
    #1;
    check("b2b_gnt1", gnt, 4'b0010);
    cyc();
    req = 4'b0000;
    #1;
    check("b2b_rvalid3", rvalid, 4'b1000);
    check("b2b_rdata3", rdata, mem_val(32'h30));
    cyc();
    check("b2b_rvalid0", rvalid, 4'b0001);
    check("b2b_rdata0", rdata, mem_val(32'h40));
    cyc();
    check("b2b_rvalid1", rvalid, 4'b0010);
    check("b2b_rdata1", rdata, mem_val(32'h50));
    cyc();
    check("b2b_rvalid_off", rvalid, 0);

    // Reset right after a read acceptance discards the read and restarts ptr at 0.
    set_port(3, 1'b0, 32'h60, 32'h0);
    req = 4'b1000;
    #1;
    check("rstrd_gnt", gnt, 4'b1000);
    cyc();
    reset = 1'b1;
    req   = 4'hF;
    #1;
    check("rstrd_gnt_in_reset", gnt, 0);
    cyc();
    reset = 1'b0;
    req   = 4'b1010;
    #1;
    check("rstrd_post_gnt", gnt, 4'b0010);
    check("rstrd_rvalid_c2", rvalid, 0);
    check("rstrd_we", mc_we, 0);
    check("rstrd_addr", mc_addr, 0);
    cyc();
    req = 4'b0000;
    #1;
    check("rstrd_rvalid_c3", rvalid, 0);
    check("rstrd_post_addr", mc_addr, 32'h50);
    cyc();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
